// File: rtl/sdcard_pkg.sv
// Shared SD card block-interface encodings and sector geometry.
// Used by sdcard_dma and the surrounding card controller.
package sdcard_pkg;

   typedef enum logic [2:0] {
      CmdIdle  = 3'd0,
      CmdRead  = 3'd1,
      CmdNext  = 3'd2,
      CmdPut   = 3'd3,
      CmdWrite = 3'd4
   } sd_cmd_e;

   localparam int unsigned SectorBytes = 512;
   localparam logic [8:0]  LastByte    = 9'(SectorBytes - 1);

endpackage

// File: rtl/sdcard_dma.sv
// Sector-granular DMA between an SD card block port and byte memory.
// Memory->card transfers are built only with SDCARD_DMA_WRITE_EN defined.
module sdcard_dma
   import sdcard_pkg::*;
#(
   parameter logic [23:0] TimeoutCycles = 24'd10_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        dir,
   input  logic [31:0] first_sector,
   input  logic [15:0] sector_count,
   input  logic [31:0] mem_base,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [2:0]  sd_command,
   output logic [31:0] sd_sector,
   output logic [7:0]  sd_data_in,
   input  logic [7:0]  sd_data_out,
   input  logic        sd_busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      Idle, CmdIssue, WaitBusyHigh, WaitBusyLow,
      MemXfer, SdStep, NextSector, Finish
   } state_e;

   localparam logic [23:0] WaitLast = TimeoutCycles - 24'd1;

   state_e      state, state_nx;
   sd_cmd_e     cmd;
   logic        wr, reject, flush, err_q, accept;
   logic [31:0] sector, base;
   logic [15:0] remaining;
   logic [22:0] sect_idx;
   logic [8:0]  byte_cnt;
   logic [23:0] wait_cnt;
   logic [7:0]  data_in_q;

   assign accept = (state == Idle) && start && !sd_busy;

`ifdef SDCARD_DMA_WRITE_EN
   logic dir_q;

   always_ff @(posedge clk) begin
      if (!rst_n)      dir_q <= 1'b0;
      else if (accept) dir_q <= dir;
   end

   assign wr     = dir_q;
   assign reject = 1'b0;
`else
   assign wr     = 1'b0;
   assign reject = dir;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= Idle;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cmd      = CmdIdle;
      unique case (state)
         Idle: begin
            if (accept) begin
               if (sector_count == 16'd0 || reject) state_nx = Finish;
               else                                 state_nx = CmdIssue;
            end
         end
         CmdIssue: begin
            if (!wr) begin
               cmd      = CmdRead;
               state_nx = WaitBusyHigh;
            end else if (flush) begin
               cmd      = CmdWrite;
               state_nx = WaitBusyHigh;
            end else begin
               state_nx = MemXfer;
            end
         end
         WaitBusyHigh: state_nx = sd_busy ? WaitBusyLow : Finish;
         WaitBusyLow: begin
            if (!sd_busy)                 state_nx = wr ? NextSector : MemXfer;
            else if (wait_cnt == WaitLast) state_nx = Finish;
         end
         MemXfer: if (mem_ack) state_nx = SdStep;
         SdStep: begin
            cmd = wr ? CmdPut : CmdNext;
            // byte_cnt wraps to 0 here, realigning with the card buffer
            if (byte_cnt == LastByte) state_nx = wr ? CmdIssue : NextSector;
            else                      state_nx = MemXfer;
         end
         NextSector: state_nx = (remaining == 16'd1) ? Finish : CmdIssue;
         Finish:     state_nx = Idle;
         default:    state_nx = Idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sector    <= '0;
         base      <= '0;
         remaining <= '0;
         sect_idx  <= '0;
         byte_cnt  <= '0;
         wait_cnt  <= '0;
         data_in_q <= '0;
         flush     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         unique case (state)
            Idle: begin
               if (accept) begin
                  sector    <= first_sector;
                  remaining <= sector_count;
                  base      <= mem_base;
                  sect_idx  <= '0;
                  byte_cnt  <= '0;
                  flush     <= 1'b0;
                  err_q     <= reject;
               end
            end
            CmdIssue: begin
               wait_cnt <= '0;
               flush    <= 1'b0;
            end
            WaitBusyHigh: if (!sd_busy) err_q <= 1'b1;
            WaitBusyLow: begin
               wait_cnt <= wait_cnt + 24'd1;
               if (sd_busy && wait_cnt == WaitLast) err_q <= 1'b1;
            end
            MemXfer: if (mem_ack && wr) data_in_q <= mem_rdata;
            SdStep: begin
               byte_cnt <= byte_cnt + 9'd1;
               if (byte_cnt == LastByte && wr) flush <= 1'b1;
            end
            NextSector: begin
               sector    <= sector + 32'd1;
               remaining <= remaining - 16'd1;
               sect_idx  <= sect_idx + 23'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy       = (state != Idle);
   assign done       = (state == Finish);
   assign error      = done & err_q;
   assign sd_command = cmd;
   assign sd_sector  = sector;
   assign sd_data_in = data_in_q;
   assign mem_req    = (state == MemXfer);
   assign mem_we     = mem_req & ~wr;
   assign mem_addr   = base + {sect_idx, byte_cnt};
   assign mem_wdata  = sd_data_out;

endmodule

// File: doc/sdcard_dma.md
SDCARD_DMA -- requirements
Module: sdcard_dma

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 24'd10_000_000, max cycles waiting on sd_busy per sector before error.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports start  input  1, and dir  input  1 (0 = card->memory, 1 = memory->card): transfer request, sampled in Idle only.
REQ-005 SHALL have ports first_sector  input  32, sector_count  input  16, mem_base  input  32: transfer descriptor, latched on start.
REQ-006 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), error  output  1 (valid with done).
REQ-007 SHALL have ports sd_command  output  3, sd_sector  output  32, sd_data_in  output  8, sd_data_out  input  8, sd_busy  input  1: SD card block command interface.
REQ-008 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  8, mem_rdata  input  8, mem_ack  input  1: byte memory port.

Function
REQ-009 SHALL use states Idle, CmdIssue, WaitBusyHigh, WaitBusyLow, MemXfer, SdStep, NextSector, Finish.
REQ-010 SHALL, in Idle with start=1 and sd_busy=0: latch descriptor, go CmdIssue (sector_count=0 -> Finish with error=0, no card command).
REQ-011 SHALL hold sd_command at 0 except single-cycle pulses of 1 (read), 2 (next byte), 3 (put byte), 4 (write sector).
REQ-012 SHALL, in CmdIssue with dir=0, pulse command 1 with sd_sector=current sector, then WaitBusyHigh.
REQ-013 SHALL, in WaitBusyHigh, wait exactly one cycle for sd_busy=1; sd_busy=0 after that cycle -> error.
REQ-014 SHALL, in WaitBusyLow, count cycles; sd_busy=0 -> MemXfer (read) or NextSector (write); count reaching TimeoutCycles -> Finish with error=1.
REQ-015 SHALL, read direction, per byte: assert mem_req/mem_we=1 with mem_wdata=sd_data_out and mem_addr=mem_base+byte offset, hold until mem_ack, then pulse command 2 in SdStep.
REQ-016 SHALL, write direction, per byte: assert mem_req/mem_we=0, hold until mem_ack, register mem_rdata into sd_data_in with a command 3 pulse in the same cycle.
REQ-017 SHALL count exactly 512 bytes per sector in a 9-bit counter (wrap 511->0 ends sector) so the card buffer index returns to 0.
REQ-018 SHALL, write direction, after 512th command 3 pulse command 4 with sd_sector, then WaitBusyHigh/WaitBusyLow.
REQ-019 SHALL, in NextSector: increment sector (32-bit wrap) and decrement remaining; remaining=0 -> Finish, else CmdIssue.
REQ-020 SHALL compute mem_addr as mem_base + sector_index*512 + byte offset, 32-bit modulo.
REQ-021 SHALL pulse done for one cycle in Finish, return to Idle; busy=1 in every state except Idle.
REQ-022 SHALL ignore start while busy; start in the done cycle is not accepted.

Reset
REQ-023 SHALL, on rst_n=0 at a clk edge, enter Idle with busy=0, done=0, error=0, mem_req=0, mem_we=0, sd_command=0, sd_sector=0, sd_data_in=0, counters 0, from any state, abandoning the transfer.

Configuration
REQ-024 SHALL compile memory->card support only when SDCARD_DMA_WRITE_EN is defined; undefined: dir=1 with start -> one-cycle done with error=1, commands 3/4 never issued.

Structure
REQ-025 SHALL take SD command encodings (Idle 0, Read 1, Next 2, Put 3, Write 4) and the 512 sector-size constant from shared package sdcard_pkg; the state enum stays local.
REQ-026 SHALL be a single module; no sub-module is warranted.

Verification
REQ-027 Read 1 sector from 5 to mem_base 0x1000, card model 0x00..0xFF repeating -> 512 mem writes 0x1000..0x11FF, data = addr[7:0], exactly 512 command 2 pulses, done with error=0.
REQ-028 Read 3 sectors from 0xFFFFFFFF -> command 1 with sectors 0xFFFFFFFF, 0, 1; 1536 mem writes ending 0x15FF.
REQ-029 Write (WRITE_EN) 2 sectors to 10 from memory pattern -> 1024 command 3 pulses, command 4 at sectors 10 and 11, card model receives identical bytes.
REQ-030 Card model holds sd_busy high forever, TimeoutCycles=100 -> done with error=1 ~101 cycles after command 1; no mem traffic.
REQ-031 sector_count=0 -> done next cycle, error=0, no commands; rst_n low mid-sector-2 -> all outputs 0 next cycle, new start accepted.
REQ-032 Random 0-7 cycle mem_ack delays on 1-sector read -> same data as REQ-027, mem_req held stable until ack.
